// File: rtl/register_alias_table_3way.sv
// Three-wide register alias table: speculative (SRAT) and committed (CRAT) maps,
// intra-group dependency bypass, registered rename output stage and flush recovery.
module register_alias_table_3way #(
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_W    = 6,
    parameter int unsigned AR_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        dec_valid_i,
    input  logic [AR_W-1:0]   rs1_i_0,
    input  logic [AR_W-1:0]   rs1_i_1,
    input  logic [AR_W-1:0]   rs1_i_2,
    input  logic [AR_W-1:0]   rs2_i_0,
    input  logic [AR_W-1:0]   rs2_i_1,
    input  logic [AR_W-1:0]   rs2_i_2,
    input  logic [AR_W-1:0]   rd_i_0,
    input  logic [AR_W-1:0]   rd_i_1,
    input  logic [AR_W-1:0]   rd_i_2,
    input  logic [2:0]        rd_we_i,
    output logic              dec_ready_o,
    input  logic [PHYS_W-1:0] free_count_i,
    output logic [2:0]        alloc_en_o,
    input  logic [PHYS_W-1:0] alloc_tag_i_0,
    input  logic [PHYS_W-1:0] alloc_tag_i_1,
    input  logic [PHYS_W-1:0] alloc_tag_i_2,
    output logic [2:0]        ren_valid_o,
    output logic [PHYS_W-1:0] prs1_o_0,
    output logic [PHYS_W-1:0] prs1_o_1,
    output logic [PHYS_W-1:0] prs1_o_2,
    output logic [PHYS_W-1:0] prs2_o_0,
    output logic [PHYS_W-1:0] prs2_o_1,
    output logic [PHYS_W-1:0] prs2_o_2,
    output logic [PHYS_W-1:0] prd_o_0,
    output logic [PHYS_W-1:0] prd_o_1,
    output logic [PHYS_W-1:0] prd_o_2,
    output logic [PHYS_W-1:0] old_prd_o_0,
    output logic [PHYS_W-1:0] old_prd_o_1,
    output logic [PHYS_W-1:0] old_prd_o_2,
    input  logic              ren_ready_i,
    input  logic [2:0]        commit_valid_i,
    input  logic [AR_W-1:0]   commit_rd_i_0,
    input  logic [AR_W-1:0]   commit_rd_i_1,
    input  logic [AR_W-1:0]   commit_rd_i_2,
    input  logic [PHYS_W-1:0] commit_prd_i_0,
    input  logic [PHYS_W-1:0] commit_prd_i_1,
    input  logic [PHYS_W-1:0] commit_prd_i_2,
    input  logic              flush_i
);

    logic [AR_W-1:0]   rs1 [3];
    logic [AR_W-1:0]   rs2 [3];
    logic [AR_W-1:0]   rd [3];
    logic [PHYS_W-1:0] tag [3];
    logic [AR_W-1:0]   c_rd [3];
    logic [PHYS_W-1:0] c_prd [3];

    assign rs1   = '{rs1_i_0, rs1_i_1, rs1_i_2};
    assign rs2   = '{rs2_i_0, rs2_i_1, rs2_i_2};
    assign rd    = '{rd_i_0, rd_i_1, rd_i_2};
    assign tag   = '{alloc_tag_i_0, alloc_tag_i_1, alloc_tag_i_2};
    assign c_rd  = '{commit_rd_i_0, commit_rd_i_1, commit_rd_i_2};
    assign c_prd = '{commit_prd_i_0, commit_prd_i_1, commit_prd_i_2};

    logic [PHYS_W-1:0] srat_q [ARCH_REGS];
    logic [PHYS_W-1:0] srat_d [ARCH_REGS];
    logic [PHYS_W-1:0] crat_q [ARCH_REGS];
    logic [PHYS_W-1:0] crat_d [ARCH_REGS];

    logic [2:0]        ren_valid_q, ren_valid_d;
    logic [PHYS_W-1:0] prs1_q [3];
    logic [PHYS_W-1:0] prs1_d [3];
    logic [PHYS_W-1:0] prs2_q [3];
    logic [PHYS_W-1:0] prs2_d [3];
    logic [PHYS_W-1:0] prd_q [3];
    logic [PHYS_W-1:0] prd_d [3];
    logic [PHYS_W-1:0] old_q [3];
    logic [PHYS_W-1:0] old_d [3];

    logic [2:0] need;
    logic [1:0] num_need;
    logic       can_out;
    logic       fire;

    // Handshake: the group is taken whole only if every allocating slot gets a tag.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            need[k] = dec_valid_i[k] & rd_we_i[k] & (rd[k] != '0);
        end
        num_need    = 2'(need[0]) + 2'(need[1]) + 2'(need[2]);
        can_out     = (ren_valid_q == 3'b000) | ren_ready_i;
        dec_ready_o = can_out & (free_count_i >= PHYS_W'(num_need)) & ~flush_i;
        fire        = (dec_valid_i != 3'b000) & dec_ready_o;
        alloc_en_o  = fire ? need : 3'b000;
    end

    // Rename lookup; a later older slot overrides an earlier one so the youngest writer wins.
    logic [PHYS_W-1:0] prs1_n [3];
    logic [PHYS_W-1:0] prs2_n [3];
    logic [PHYS_W-1:0] old_n [3];
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            prs1_n[k] = (rs1[k] == '0) ? '0 : srat_q[rs1[k]];
            prs2_n[k] = (rs2[k] == '0) ? '0 : srat_q[rs2[k]];
            old_n[k]  = (rd[k] == '0) ? '0 : srat_q[rd[k]];
            for (int j = 0; j < k; j++) begin
                if (need[j] && rd[j] == rs1[k]) prs1_n[k] = tag[j];
                if (need[j] && rd[j] == rs2[k]) prs2_n[k] = tag[j];
                if (need[j] && rd[j] == rd[k])  old_n[k]  = tag[j];
            end
        end
    end

    // Table next state: commits in slot order, then flush restore or speculative writes.
    always_comb begin
        srat_d = srat_q;
        crat_d = crat_q;
        for (int k = 0; k < 3; k++) begin
            if (commit_valid_i[k] && c_rd[k] != '0) crat_d[c_rd[k]] = c_prd[k];
        end
        if (flush_i) begin
            srat_d = crat_d;
        end else if (fire) begin
            for (int k = 0; k < 3; k++) begin
                if (need[k]) srat_d[rd[k]] = tag[k];
            end
        end
        srat_d[0] = '0;
        crat_d[0] = '0;
    end

    // Output stage next state: load on fire, drain when downstream is free, hold on stall.
    always_comb begin
        ren_valid_d = ren_valid_q;
        prs1_d      = prs1_q;
        prs2_d      = prs2_q;
        prd_d       = prd_q;
        old_d       = old_q;
        if (flush_i) begin
            ren_valid_d = 3'b000;
        end else if (fire) begin
            ren_valid_d = dec_valid_i;
            prs1_d      = prs1_n;
            prs2_d      = prs2_n;
            old_d       = old_n;
            for (int k = 0; k < 3; k++) prd_d[k] = need[k] ? tag[k] : '0;
        end else if (can_out) begin
            ren_valid_d = 3'b000;
        end
    end

    // State registers; reset maps every architectural register to its own physical tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                srat_q[i] <= PHYS_W'(i);
                crat_q[i] <= PHYS_W'(i);
            end
            ren_valid_q <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                prs1_q[k] <= '0;
                prs2_q[k] <= '0;
                prd_q[k]  <= '0;
                old_q[k]  <= '0;
            end
        end else begin
            srat_q      <= srat_d;
            crat_q      <= crat_d;
            ren_valid_q <= ren_valid_d;
            prs1_q      <= prs1_d;
            prs2_q      <= prs2_d;
            prd_q       <= prd_d;
            old_q       <= old_d;
        end
    end

    assign ren_valid_o = ren_valid_q;
    assign prs1_o_0    = prs1_q[0];
    assign prs1_o_1    = prs1_q[1];
    assign prs1_o_2    = prs1_q[2];
    assign prs2_o_0    = prs2_q[0];
    assign prs2_o_1    = prs2_q[1];
    assign prs2_o_2    = prs2_q[2];
    assign prd_o_0     = prd_q[0];
    assign prd_o_1     = prd_q[1];
    assign prd_o_2     = prd_q[2];
    assign old_prd_o_0 = old_q[0];
    assign old_prd_o_1 = old_q[1];
    assign old_prd_o_2 = old_q[2];

endmodule

// File: tb/tb_register_alias_table_3way.sv
// Bench for the 3-way rename table: directed scenarios followed by random traffic,
// all checked against a sequential-semantics map model.
module tb_register_alias_table_3way;

    localparam int AW = 5;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    dec_valid, rd_we, commit_valid, alloc_en, ren_valid;
    logic [AW-1:0] rs1 [3];
    logic [AW-1:0] rs2 [3];
    logic [AW-1:0] rd [3];
    logic [AW-1:0] commit_rd [3];
    logic [PW-1:0] tag [3];
    logic [PW-1:0] commit_prd [3];
    logic [PW-1:0] prs1_o [3];
    logic [PW-1:0] prs2_o [3];
    logic [PW-1:0] prd_o [3];
    logic [PW-1:0] old_o [3];
    logic [PW-1:0] free_count;
    logic          dec_ready, ren_ready, flush;

    int checks = 0;
    int errors = 0;

    register_alias_table_3way dut (
        .clk(clk), .rst_n(rst_n), .dec_valid_i(dec_valid),
        .rs1_i_0(rs1[0]), .rs1_i_1(rs1[1]), .rs1_i_2(rs1[2]),
        .rs2_i_0(rs2[0]), .rs2_i_1(rs2[1]), .rs2_i_2(rs2[2]),
        .rd_i_0(rd[0]), .rd_i_1(rd[1]), .rd_i_2(rd[2]),
        .rd_we_i(rd_we), .dec_ready_o(dec_ready), .free_count_i(free_count),
        .alloc_en_o(alloc_en),
        .alloc_tag_i_0(tag[0]), .alloc_tag_i_1(tag[1]), .alloc_tag_i_2(tag[2]),
        .ren_valid_o(ren_valid),
        .prs1_o_0(prs1_o[0]), .prs1_o_1(prs1_o[1]), .prs1_o_2(prs1_o[2]),
        .prs2_o_0(prs2_o[0]), .prs2_o_1(prs2_o[1]), .prs2_o_2(prs2_o[2]),
        .prd_o_0(prd_o[0]), .prd_o_1(prd_o[1]), .prd_o_2(prd_o[2]),
        .old_prd_o_0(old_o[0]), .old_prd_o_1(old_o[1]), .old_prd_o_2(old_o[2]),
        .ren_ready_i(ren_ready), .commit_valid_i(commit_valid),
        .commit_rd_i_0(commit_rd[0]), .commit_rd_i_1(commit_rd[1]),
        .commit_rd_i_2(commit_rd[2]),
        .commit_prd_i_0(commit_prd[0]), .commit_prd_i_1(commit_prd[1]),
        .commit_prd_i_2(commit_prd[2]),
        .flush_i(flush)
    );

    // Reference model: maps as plain arrays, group renamed slot by slot in program order.
    int         m_srat [32];
    int         m_crat [32];
    logic [2:0] m_valid;
    int         m_prs1 [3];
    int         m_prs2 [3];
    int         m_prd [3];
    int         m_old [3];
    logic [2:0] e_need, e_alloc;
    bit         e_can, e_ready, e_fire;

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", t, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_srat[i] = i;
            m_crat[i] = i;
        end
        m_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            m_prs1[k] = 0; m_prs2[k] = 0; m_prd[k] = 0; m_old[k] = 0;
        end
    endtask

    task automatic model_comb();
        int num;
        num = 0;
        for (int k = 0; k < 3; k++) begin
            e_need[k] = dec_valid[k] && rd_we[k] && (rd[k] != 0);
            if (e_need[k]) num++;
        end
        e_can   = (m_valid == 3'b000) || ren_ready;
        e_ready = e_can && (int'(free_count) >= num) && !flush;
        e_fire  = (dec_valid != 3'b000) && e_ready;
        e_alloc = e_fire ? e_need : 3'b000;
    endtask

    task automatic model_seq();
        for (int k = 0; k < 3; k++) begin
            if (commit_valid[k] && commit_rd[k] != 0) m_crat[commit_rd[k]] = int'(commit_prd[k]);
        end
        if (flush) begin
            for (int i = 0; i < 32; i++) m_srat[i] = m_crat[i];
            m_valid = 3'b000;
        end else if (e_fire) begin
            for (int k = 0; k < 3; k++) begin
                m_prs1[k] = (rs1[k] == 0) ? 0 : m_srat[rs1[k]];
                m_prs2[k] = (rs2[k] == 0) ? 0 : m_srat[rs2[k]];
                m_old[k]  = (rd[k] == 0) ? 0 : m_srat[rd[k]];
                if (e_need[k]) begin
                    m_prd[k] = int'(tag[k]);
                    m_srat[rd[k]] = int'(tag[k]);
                end else begin
                    m_prd[k] = 0;
                end
            end
            m_valid = dec_valid;
        end else if (e_can) begin
            m_valid = 3'b000;
        end
    endtask

    task automatic settle();
        model_comb();
        #1;
        chk("dec_ready", 32'(dec_ready), 32'(e_ready));
        chk("alloc_en", 32'(alloc_en), 32'(e_alloc));
    endtask

    task automatic clock();
        @(posedge clk);
        model_seq();
        #1;
        chk("ren_valid", 32'(ren_valid), 32'(m_valid));
        for (int k = 0; k < 3; k++) begin
            if (m_valid[k]) begin
                chk($sformatf("prs1_%0d", k), 32'(prs1_o[k]), 32'(m_prs1[k]));
                chk($sformatf("prs2_%0d", k), 32'(prs2_o[k]), 32'(m_prs2[k]));
                chk($sformatf("prd_%0d", k), 32'(prd_o[k]), 32'(m_prd[k]));
                chk($sformatf("old_prd_%0d", k), 32'(old_o[k]), 32'(m_old[k]));
            end
        end
    endtask

    task automatic clear_in();
        dec_valid = 3'b000; rd_we = 3'b000; commit_valid = 3'b000;
        free_count = 6'd32; ren_ready = 1'b1; flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rs1[k] = '0; rs2[k] = '0; rd[k] = '0; commit_rd[k] = '0;
            tag[k] = 6'(32 + k); commit_prd[k] = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        model_reset();
        #3;
        chk("reset_ren_valid", 32'(ren_valid), 32'd0);
        chk("reset_prd0", 32'(prd_o[0]), 32'd0);
        #9 rst_n = 1'b1;  // released at t=12, between edges

        // Single rename after reset.
        dec_valid = 3'b001; rd_we = 3'b001; rs1[0] = 5; rd[0] = 3; tag[0] = 32;
        settle();
        chk("d021_alloc", 32'(alloc_en), 32'd1);
        clock();
        chk("d021_prs1", 32'(prs1_o[0]), 32'd5);
        chk("d021_prd", 32'(prd_o[0]), 32'd32);
        chk("d021_old", 32'(old_o[0]), 32'd3);

        // Intra-group bypass on x7, plus SRAT[3] read by slot 2.
        clear_in();
        dec_valid = 3'b111; rd_we = 3'b011;
        rd[0] = 7; tag[0] = 32; rs1[1] = 7; rd[1] = 7; tag[1] = 33; rs2[2] = 7; rs1[2] = 3;
        settle();
        clock();
        chk("d022_prs1_1", 32'(prs1_o[1]), 32'd32);
        chk("d022_old_1", 32'(old_o[1]), 32'd32);
        chk("d022_prs2_2", 32'(prs2_o[2]), 32'd33);
        chk("d021_srat3", 32'(prs1_o[2]), 32'd32);
        clear_in();
        dec_valid = 3'b001; rs1[0] = 7;
        settle();
        clock();
        chk("d022_srat7", 32'(prs1_o[0]), 32'd33);

        // Not enough free tags: the whole group waits.
        clear_in();
        dec_valid = 3'b111; rd_we = 3'b111; rd[0] = 1; rd[1] = 2; rd[2] = 6;
        tag[0] = 44; tag[1] = 45; tag[2] = 46; free_count = 2;
        settle();
        chk("d023_ready", 32'(dec_ready), 32'd0);
        chk("d023_alloc", 32'(alloc_en), 32'd0);
        clock();
        free_count = 3;
        settle();
        chk("d023_alloc_fire", 32'(alloc_en), 32'd7);
        clock();
        chk("d023_old2", 32'(old_o[2]), 32'd6);

        // Downstream stall holds outputs for three cycles.
        clear_in();
        ren_ready = 1'b0; dec_valid = 3'b111; rd_we = 3'b001; rd[0] = 5; tag[0] = 50;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("d024_ready", 32'(dec_ready), 32'd0);
            chk("d024_alloc", 32'(alloc_en), 32'd0);
            clock();
            chk("d024_hold_valid", 32'(ren_valid), 32'd7);
            chk("d024_hold_prd1", 32'(prd_o[1]), 32'd45);
        end
        ren_ready = 1'b1;
        settle();
        chk("d024_alloc_go", 32'(alloc_en), 32'd1);
        clock();
        chk("d024_new_prd", 32'(prd_o[0]), 32'd50);

        // Commit then flush recovery.
        clear_in();
        dec_valid = 3'b001; rd_we = 3'b001; rd[0] = 4; tag[0] = 40;
        settle(); clock();
        clear_in();
        commit_valid = 3'b001; commit_rd[0] = 4; commit_prd[0] = 40;
        settle(); clock();
        clear_in();
        dec_valid = 3'b001; rd_we = 3'b001; rd[0] = 4; tag[0] = 41;
        settle(); clock();
        chk("d025_old41", 32'(old_o[0]), 32'd40);
        clear_in();
        flush = 1'b1; dec_valid = 3'b001; rd_we = 3'b001; rd[0] = 6; tag[0] = 60;
        settle();
        chk("d025_flush_alloc", 32'(alloc_en), 32'd0);
        clock();
        chk("d025_flush_valid", 32'(ren_valid), 32'd0);
        clear_in();
        dec_valid = 3'b001; rs1[0] = 4;
        settle(); clock();
        chk("d025_srat4", 32'(prs1_o[0]), 32'd40);
        clear_in();
        flush = 1'b1; commit_valid = 3'b001; commit_rd[0] = 9; commit_prd[0] = 50;
        settle(); clock();
        clear_in();
        dec_valid = 3'b001; rs1[0] = 9;
        settle(); clock();
        chk("d025_srat9", 32'(prs1_o[0]), 32'd50);

        // Writes to x0 allocate nothing; then reset during a stall.
        clear_in();
        dec_valid = 3'b001; rd_we = 3'b001; rd[0] = 0; rs1[0] = 0; tag[0] = 33;
        settle();
        chk("d026_alloc", 32'(alloc_en), 32'd0);
        clock();
        chk("d026_prd", 32'(prd_o[0]), 32'd0);
        chk("d026_prs1", 32'(prs1_o[0]), 32'd0);
        clear_in();
        ren_ready = 1'b0; dec_valid = 3'b111; rd_we = 3'b111;
        rd[0] = 1; rd[1] = 2; rd[2] = 3;
        settle(); clock();
        settle();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("d026_async_valid", 32'(ren_valid), 32'd0);
        #1 rst_n = 1'b1;
        clear_in();
        dec_valid = 3'b011; rs1[0] = 4; rs2[0] = 9; rs1[1] = 3;
        settle(); clock();
        chk("d026_id4", 32'(prs1_o[0]), 32'd4);
        chk("d026_id9", 32'(prs2_o[0]), 32'd9);
        chk("d026_id3", 32'(prs1_o[1]), 32'd3);

        // Random traffic with heavy register overlap.
        for (int n = 0; n < 600; n++) begin
            dec_valid  = 3'($urandom_range(0, 7));
            rd_we      = 3'($urandom_range(0, 7));
            free_count = 6'($urandom_range(0, 4));
            ren_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            commit_valid = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                rs1[k] = 5'($urandom_range(0, 7));
                rs2[k] = 5'($urandom_range(0, 7));
                rd[k]  = 5'($urandom_range(0, 7));
                tag[k] = 6'($urandom_range(32, 63));
                commit_rd[k]  = 5'($urandom_range(0, 7));
                commit_prd[k] = 6'($urandom_range(0, 63));
            end
            settle();
            clock();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
